// File: rtl/fp32_mac_sequencer.sv
// rtl/fp32_mac_sequencer.sv - frame capture, MAC issue/watchdog and TX hand-off for fp32_rx_mac_tx
module fp32_mac_sequencer #(
    parameter int          MAC_TIMEOUT = 1024,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] ERR_PATTERN = 32'h7FC00000
) (
    input  logic             CLK_I,
    input  logic             RSTL_I,
    input  logic             RX_VALID_I,
    input  logic [95:0]      RX_DATA_I,
    output logic             RX_READY_O,
    output logic             MAC_START_O,
    output logic [31:0]      MAC_A_O,
    output logic [31:0]      MAC_B_O,
    output logic [31:0]      MAC_C_O,
    input  logic             MAC_DONE_I,
    input  logic [31:0]      MAC_RESULT_I,
    output logic             TX_VALID_O,
    output logic [31:0]      TX_DATA_O,
    input  logic             TX_READY_I,
    output logic             BUSY_O,
    output logic             ERR_TIMEOUT_O,
    output logic [CNT_W-1:0] FRAME_CNT_O
);

    localparam int               TMR_W    = $clog2(MAC_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_MAC_WAIT = 2'd2,
        ST_SEND     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             seen;
    logic [TMR_W-1:0] timer;
    logic             accept;
    logic             take_result;
    logic             take_timeout;
    logic             tx_fire;

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        take_result  = 1'b0;
        take_timeout = 1'b0;
        tx_fire      = 1'b0;
        RX_READY_O   = 1'b0;
        MAC_START_O  = 1'b0;
        TX_VALID_O   = 1'b0;
        BUSY_O       = 1'b1;
        case (state)
            ST_IDLE: begin
                RX_READY_O = 1'b1;
                BUSY_O     = 1'b0;
                if (RX_VALID_I && !seen) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                MAC_START_O = 1'b1;
                state_nxt   = ST_MAC_WAIT;
            end
            ST_MAC_WAIT: begin
                // A done arriving on the last watchdog cycle still counts as a result.
                if (MAC_DONE_I) begin
                    take_result = 1'b1;
                    state_nxt   = ST_SEND;
                end else if (timer == TMR_LAST) begin
                    take_timeout = 1'b1;
                    state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                TX_VALID_O = 1'b1;
                if (TX_READY_I) begin
                    tx_fire   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // seen blocks a level-held valid from re-triggering; only a low valid re-arms it.
    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            seen <= 1'b0;
        end else if (!RX_VALID_I) begin
            seen <= 1'b0;
        end else if (accept) begin
            seen <= 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            MAC_A_O <= 32'd0;
            MAC_B_O <= 32'd0;
            MAC_C_O <= 32'd0;
        end else if (accept) begin
            MAC_A_O <= RX_DATA_I[31:0];
            MAC_B_O <= RX_DATA_I[63:32];
            MAC_C_O <= RX_DATA_I[95:64];
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            timer <= '0;
        end else if (state == ST_ISSUE) begin
            timer <= '0;
        end else if (state == ST_MAC_WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            TX_DATA_O     <= 32'd0;
            ERR_TIMEOUT_O <= 1'b0;
        end else if (take_result) begin
            TX_DATA_O <= MAC_RESULT_I;
        end else if (take_timeout) begin
            TX_DATA_O     <= ERR_PATTERN;
            ERR_TIMEOUT_O <= 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            FRAME_CNT_O <= '0;
        end else if (tx_fire) begin
            FRAME_CNT_O <= FRAME_CNT_O + 1'b1;
        end
    end

endmodule
